note_tone_gen: RTL and testbench
================================

// Module: note_tone_gen
// PURPOSE
//  Consumer of the 5 MHz clock-enable pulse produced by the 50 MHz->5 MHz divider.
//  Turns a key/note code into a 50%-duty square wave on the buzzer pin.
//  Note changes use a valid/ready handshake and take effect only at a full-period
//  boundary (output low), so the speaker never sees a runt pulse.
// PARAMETERS
//  CNT_W   14  width of half-period counter; must hold 9556 (largest LUT entry)
// PORTS
//  clk         in   1      system clock, 50 MHz
//  rst_n       in   1      reset, asynchronous, active-low
//  tick        in   1      1-clk-wide enable pulse, nominally 1 per 10 clk (5 MHz)
//  note_code   in   4      0=rest, 1..8=C4,D4,E4,F4,G4,A4,B4,C5, 9..15=rest
//  note_valid  in   1      note_code is offered this cycle
//  note_ready  out  1      block accepts note_code when valid&&ready
//  tone_out    out  1      square wave to buzzer
//  playing     out  1      1 while a tone is active (PLAY or SWITCH)
//  cur_note    out  4      code of the note currently sounding, 0 when silent
// BEHAVIOUR
//  Reset values: tone_out=0, playing=0, cur_note=0, note_ready=1, cnt=0, state=IDLE.
//  Reset mid-operation: all state cleared immediately, no pending note retained.
//  Half-period LUT (5 MHz ticks, round(5e6/(2f))): 1:9556 2:8513 3:7584 4:7159
//   5:6378 6:5682 7:5062 8:4778. Codes 0,9..15 = rest. half and cnt are CNT_W bits.
//  Counter advances only on clk edges with tick=1; without tick all state holds
//   (handshake still evaluated every clk).
//  States:
//   IDLE: tone_out=0, note_ready=1. Accept of code 1..8 -> load half=LUT(code),
//    cnt=0, cur_note=code, playing=1, -> PLAY. Accept of rest: stay IDLE.
//   PLAY: note_ready=1. On tick: cnt==half-1 -> cnt=0, tone_out toggles; else cnt+1.
//    First rising edge = half ticks after entry. Accept (any code, incl. same note
//    or rest) -> store pend_code, -> SWITCH same cycle (counting continues).
//   SWITCH: note_ready=0 (valid ignored). Counts as PLAY; at the tick where
//    cnt==half-1 and tone_out==1: tone_out=0, cnt=0 and then: pend rest -> IDLE,
//    playing=0, cur_note=0; else half=LUT(pend), cur_note=pend, -> PLAY.
//    Boundary while tone_out==0 is an ordinary toggle to 1.
//  Accept on the same clk as a tick in PLAY: tick processed normally, state->SWITCH.
//  Accept and wave-end on same tick impossible (ready=0 in SWITCH).
//  Latency IDLE accept -> playing=1: 1 clk. Stop latency: <= 2*half ticks.
//  No arithmetic wrap: cnt never exceeds half-1 by construction.
// CONFIGURATION
//  OCTAVE_SHIFT_EN defined: extra input octave_up (1 bit), sampled with note_code on
//   accept (stored with pend in SWITCH); when 1, loaded half = LUT(code)>>1 (one
//   octave higher, e.g. A4 -> 2841). cur_note unchanged.
//  OCTAVE_SHIFT_EN undefined: port absent, half = LUT(code) always.
// TESTING (bench drives tick 1 clk in 10)
//  Reset release, no valid -> tone_out=0, playing=0, note_ready=1, cur_note=0.
//  IDLE, accept code 6 (A4) -> tone_out rises after 5682 ticks, period 11364 ticks,
//   duty exactly 5682/5682, cur_note=6.
//  Playing A4, accept code 1 (C4) mid-high-phase -> note_ready=0 until next falling
//   edge; then half 9556, cur_note=1, note_ready=1.
//  Playing, accept code 0 -> tone ends at falling edge, playing=0, state IDLE;
//   further codes 9..15 in IDLE -> no output activity.
//  tick held low 1000 clk mid-note -> tone_out and cnt frozen; resume continues count.
//  rst_n pulsed low during SWITCH -> all outputs to reset values asynchronously;
//   with OCTAVE_SHIFT_EN, code 6 + octave_up=1 -> half 2841 ticks.

Source files
------------

// File: rtl/note_tone_gen.sv
// Key/note code to 50%-duty buzzer square wave, paced by a 5 MHz tick; note changes land only
// at the falling edge. Define OCTAVE_SHIFT_EN to add the octave_up input (half-period halved).
module note_tone_gen #(
  parameter int unsigned CNT_W = 14
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [3:0] note_code,
  input  logic       note_valid,
`ifdef OCTAVE_SHIFT_EN
  input  logic       octave_up,
`endif
  output logic       note_ready,
  output logic       tone_out,
  output logic       playing,
  output logic [3:0] cur_note
);

  typedef enum logic [1:0] {StIdle, StPlay, StSwitch} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic             tone_q, tone_d;
  logic [3:0]       cur_note_q, cur_note_d;
  logic [3:0]       pend_code_q, pend_code_d;
  logic             pend_oct_q, pend_oct_d;
  logic             oct_in;
  logic             accept;
  logic             wrap;

`ifdef OCTAVE_SHIFT_EN
  assign oct_in = octave_up;
`else
  assign oct_in = 1'b0;
`endif

  function automatic logic is_rest(input logic [3:0] code);
    return !(code inside {[4'd1:4'd8]});
  endfunction

  // Half period in 5 MHz ticks, round(5e6 / (2 * f)).
  function automatic logic [CNT_W-1:0] lut_half(input logic [3:0] code, input logic oct);
    logic [CNT_W-1:0] h;
    case (code)
      4'd1:    h = CNT_W'(9556);
      4'd2:    h = CNT_W'(8513);
      4'd3:    h = CNT_W'(7584);
      4'd4:    h = CNT_W'(7159);
      4'd5:    h = CNT_W'(6378);
      4'd6:    h = CNT_W'(5682);
      4'd7:    h = CNT_W'(5062);
      4'd8:    h = CNT_W'(4778);
      default: h = '0;
    endcase
    if (oct) h = h >> 1;
    return h;
  endfunction

  assign accept = note_valid && (state_q != StSwitch);
  assign wrap   = tick && (cnt_q == half_q - CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      half_q      <= '0;
      tone_q      <= 1'b0;
      cur_note_q  <= 4'd0;
      pend_code_q <= 4'd0;
      pend_oct_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      half_q      <= half_d;
      tone_q      <= tone_d;
      cur_note_q  <= cur_note_d;
      pend_code_q <= pend_code_d;
      pend_oct_q  <= pend_oct_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    half_d      = half_q;
    tone_d      = tone_q;
    cur_note_d  = cur_note_q;
    pend_code_d = pend_code_q;
    pend_oct_d  = pend_oct_q;

    if (state_q != StIdle && tick) begin
      cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (accept && !is_rest(note_code)) begin
          half_d     = lut_half(note_code, oct_in);
          cnt_d      = '0;
          cur_note_d = note_code;
          state_d    = StPlay;
        end
      end
      StPlay: begin
        if (wrap) tone_d = ~tone_q;
        if (accept) begin
          pend_code_d = note_code;
          pend_oct_d  = oct_in;
          state_d     = StSwitch;
        end
      end
      StSwitch: begin
        if (wrap) begin
          if (tone_q) begin
            // Falling edge closes the period: only here may the note change.
            tone_d = 1'b0;
            if (is_rest(pend_code_q)) begin
              cur_note_d = 4'd0;
              state_d    = StIdle;
            end else begin
              half_d     = lut_half(pend_code_q, pend_oct_q);
              cur_note_d = pend_code_q;
              state_d    = StPlay;
            end
          end else begin
            tone_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    note_ready = (state_q != StSwitch);
    playing    = (state_q != StIdle);
    tone_out   = tone_q;
    cur_note   = cur_note_q;
  end

endmodule

// File: tb/tb_note_tone_gen.sv
// Directed bench for note_tone_gen: expected note/half-period pairs are queued on accept and
// popped when the resulting waveform edge is measured.
module tb_note_tone_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic [3:0] note_code = 4'd0;
  logic       note_valid = 1'b0;
`ifdef OCTAVE_SHIFT_EN
  logic       octave_up = 1'b0;
`endif
  logic       note_ready;
  logic       tone_out;
  logic       playing;
  logic [3:0] cur_note;

  note_tone_gen #(.CNT_W(14)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .note_code  (note_code),
    .note_valid (note_valid),
`ifdef OCTAVE_SHIFT_EN
    .octave_up  (octave_up),
`endif
    .note_ready (note_ready),
    .tone_out   (tone_out),
    .playing    (playing),
    .cur_note   (cur_note)
  );

  always #10 clk = ~clk;

  // 0: tick off, 1: tick every clk, 2: tick one clk in ten
  int tick_mode = 2;
  int div_cnt = 0;
  initial begin
    forever begin
      @(negedge clk);
      div_cnt = (div_cnt == 9) ? 0 : div_cnt + 1;
      case (tick_mode)
        1:       tick = 1'b1;
        2:       tick = (div_cnt == 0);
        default: tick = 1'b0;
      endcase
    end
  end

  typedef struct {
    int note;
    int half;
  } exp_t;
  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  initial begin
    #5ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One-cycle valid pulse; acc reports whether a tick coincided with the accepting edge.
  task automatic offer(input logic [3:0] code, output int acc);
    @(negedge clk);
    note_code  = code;
    note_valid = 1'b1;
    @(posedge clk);
    acc = tick ? 1 : 0;
    #1;
    note_valid = 1'b0;
  endtask

  // Runs until tone_out reaches lvl or max_clk clocks pass, counting ticks seen by the DUT.
  task automatic wait_edge(input logic lvl, input int max_clk, output int nt, output bit seen);
    nt   = 0;
    seen = 1'b0;
    for (int i = 0; i < max_clk; i++) begin
      @(posedge clk);
      if (tick) nt++;
      #1;
      if (tone_out === lvl) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int   nt, hi, acc, t1, t2, t3;
    bit   seen;
    exp_t e;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_tone", 32'(tone_out), 0);
    check("rst_playing", 32'(playing), 0);
    check("rst_ready", 32'(note_ready), 1);
    check("rst_cur_note", 32'(cur_note), 0);

    // A4 from idle: first rise, duty and period
    tick_mode = 1;
    sb.push_back('{6, 5682});
    offer(4'd6, acc);
    check("a4_latency_playing", 32'(playing), 1);
    wait_edge(1'b1, 20000, nt, seen);
    e = sb.pop_front();
    check("a4_first_rise", 32'(nt), 32'(e.half));
    check("a4_cur_note", 32'(cur_note), 32'(e.note));
    wait_edge(1'b0, 20000, hi, seen);
    check("a4_high", 32'(hi), 5682);
    wait_edge(1'b1, 20000, nt, seen);
    check("a4_low", 32'(nt), 5682);
    check("a4_period", 32'(hi + nt), 11364);

    // Switch to C4 mid-high phase; a second offer during SWITCH is ignored
    wait_edge(1'b0, 100, nt, seen);
    check("a4_no_early_fall", 32'(seen), 0);
    sb.push_back('{1, 9556});
    offer(4'd1, acc);
    check("switch_ready_low", 32'(note_ready), 0);
    check("switch_playing", 32'(playing), 1);
    offer(4'd3, acc);
    check("switch_ignores_valid", 32'(note_ready), 0);
    check("switch_cur_note_held", 32'(cur_note), 6);
    wait_edge(1'b0, 20000, nt, seen);
    check("switch_fall_seen", 32'(seen), 1);
    e = sb.pop_front();
    check("c4_cur_note", 32'(cur_note), 32'(e.note));
    check("c4_ready_back", 32'(note_ready), 1);
    wait_edge(1'b1, 20000, nt, seen);
    check("c4_first_rise", 32'(nt), 32'(e.half));

    // Tick held low 1000 clk mid-high: waveform frozen, count resumes
    wait_edge(1'b0, 50, t1, seen);
    check("pre_freeze_no_fall", 32'(seen), 0);
    tick_mode = 0;
    wait_edge(1'b0, 1000, t2, seen);
    check("freeze_no_fall", 32'(seen), 0);
    check("freeze_tone_high", 32'(tone_out), 1);
    tick_mode = 1;
    wait_edge(1'b0, 20000, t3, seen);
    check("c4_high_with_freeze", 32'(t1 + t2 + t3), 9556);

    // Rest accepted in low phase: one more full period, then idle
    sb.push_back('{0, 0});
    offer(4'd0, acc);
    check("stop_ready_low", 32'(note_ready), 0);
    wait_edge(1'b1, 20000, nt, seen);
    check("stop_low_phase", 32'(acc + nt), 9556);
    check("stop_still_playing", 32'(playing), 1);
    wait_edge(1'b0, 20000, nt, seen);
    check("stop_high_phase", 32'(nt), 9556);
    e = sb.pop_front();
    check("stop_playing", 32'(playing), 0);
    check("stop_cur_note", 32'(cur_note), 32'(e.note));
    check("stop_ready", 32'(note_ready), 1);

    // Rest codes 9..15 in idle do nothing
    for (int c = 9; c <= 15; c++) begin
      offer(4'(c), acc);
      check("rest_code_playing", 32'(playing), 0);
    end
    wait_edge(1'b1, 200, nt, seen);
    check("rest_no_tone", 32'(seen), 0);
    check("rest_cur_note", 32'(cur_note), 0);

    // Async reset during SWITCH, 1-in-10 ticks
    tick_mode = 2;
    offer(4'd8, acc);
    check("g_playing", 32'(playing), 1);
    check("g_cur_note", 32'(cur_note), 8);
    offer(4'd2, acc);
    check("g_switch_ready", 32'(note_ready), 0);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_tone", 32'(tone_out), 0);
    check("arst_playing", 32'(playing), 0);
    check("arst_ready", 32'(note_ready), 1);
    check("arst_cur_note", 32'(cur_note), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_edge(1'b1, 100, nt, seen);
    check("arst_no_pending", 32'(seen), 0);
    check("arst_idle", 32'(playing), 0);

`ifdef OCTAVE_SHIFT_EN
    // A4 one octave up
    tick_mode = 1;
    octave_up = 1'b1;
    sb.push_back('{6, 2841});
    offer(4'd6, acc);
    octave_up = 1'b0;
    wait_edge(1'b1, 10000, nt, seen);
    e = sb.pop_front();
    check("oct_first_rise", 32'(nt), 32'(e.half));
    check("oct_cur_note", 32'(cur_note), 32'(e.note));
`endif

    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
